pchri03_top: RTL and testbench
==============================

PCHRI03_TOP -- requirements
Module: pchri03_top

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 ena  input  1  design enable; 0 = all state frozen (outputs hold).
REQ-004 ui_in  input  8  control: [1:0] mode, [2] clear, [3] pause, [7:4] prescale divisor DIV.
REQ-005 uo_out  output  8  registered pattern output selected by mode.
REQ-006 uio_in  input  8  bidir inputs; only [7:4] used, as PWM duty high nibble.
REQ-007 uio_out  output  8  [3:0] registered status, [7:4] constant 0.
REQ-008 uio_oe  output  8  constant 8'h0F (low nibble driven, high nibble input).

Function
REQ-009 Prescaler: 4-bit counter PCNT; tick = ena & ~ui_in[3] & (PCNT == DIV).
REQ-010 PCNT, when ena=1 and pause=0: tick -> 0, else +1; when ena=0 or pause=1: holds.
REQ-011 Tick period = DIV+1 clk cycles; DIV=0 gives a tick every enabled cycle.
REQ-012 CNT: 8-bit counter, +1 on tick, wraps 8'hFF -> 8'h00.
REQ-013 LFSR: 16-bit Fibonacci; on tick LFSR <= {LFSR[14:0], LFSR[15]^LFSR[13]^LFSR[12]^LFSR[10]}.
REQ-014 DUTY = {uio_in[7:4], 4'h0}; PWM = (CNT < DUTY); DUTY=0 gives PWM constantly 0.
REQ-015 Clear (ui_in[2]=1, ena=1): synchronous; PCNT <= 0, CNT <= 0, LFSR <= 16'hACE1; overrides tick and pause.
REQ-016 Clear with ena=0 has no effect.
REQ-017 Mode mux M: 00 -> CNT; 01 -> LFSR[7:0]; 10 -> {8{PWM}}; 11 -> LFSR[15:8].
REQ-018 uo_out <= M every clk edge with ena=1 (one-cycle latency after state change); holds when ena=0.
REQ-019 uio_out[3:0] <= {PWM, LFSR[15], tick, CNT==8'hFF} every clk edge with ena=1; holds when ena=0.
REQ-020 Mode changes take effect on uo_out at the next enabled edge; they never alter CNT/LFSR/PCNT.
REQ-021 LFSR shall never reach 0 (nonzero seed, maximal polynomial); no lock-up recovery logic required.
REQ-022 Pause=1 freezes CNT/LFSR/PCNT while uo_out/uio_out continue to refresh.

Reset
REQ-023 rst_n=0 asynchronously forces PCNT=0, CNT=8'h00, LFSR=16'hACE1, uo_out=8'h00, uio_out=8'h00.
REQ-024 uio_oe=8'h0F at all times, including reset.
REQ-025 Reset asserted mid-operation aborts immediately; first enabled edge after release uses reset values.

Verification
REQ-026 Reset, ena=1, ui_in=8'h00 -> uo_out = 00,00,01,02,03... one step per clk (one-cycle lag).
REQ-027 ui_in=8'h01, DIV=0 -> first tick LFSR 16'hACE1 -> 16'h59C3; uo_out shows 8'hE1 then 8'hC3.
REQ-028 ui_in=8'h30 (DIV=3) -> CNT increments every 4th clk; uio_out[1] pulses 1 cycle every 4 cycles.
REQ-029 CNT at 8'hFF -> uio_out[0]=1; next tick CNT=8'h00, uio_out[0]=0 (wrap).
REQ-030 ui_in=8'h02, uio_in=8'h80 -> uo_out=8'hFF for CNT 0..127, 8'h00 for CNT 128..255; uio_in=8'h00 -> always 8'h00.
REQ-031 ena=0 for 10 cycles mid-count -> uo_out/uio_out/CNT frozen; resume from same value; clear during ena=1 -> CNT=0, LFSR=16'hACE1.

Source files
------------

// File: rtl/pchri03_top.sv
// Prescaled counter / LFSR / PWM pattern generator with a mode-selected registered output.
// All state advances on prescaler ticks; outputs refresh on every enabled edge.
module pchri03_top (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned PCNT_W = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LFSR_W = 16;
  localparam int unsigned STAT_W = 4;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  logic [PCNT_W-1:0] pcnt;
  logic [CNT_W-1:0]  cnt;
  logic [LFSR_W-1:0] lfsr;
  logic [STAT_W-1:0] status;

  logic [1:0]        mode_c;
  logic              clear_c;
  logic              pause_c;
  logic [PCNT_W-1:0] div_c;
  logic              tick_c;
  logic [CNT_W-1:0]  duty_c;
  logic              pwm_c;
  logic              fb_c;
  logic [CNT_W-1:0]  mux_c;
  logic [3:0]        unused_bits;

  assign mode_c  = ui_in[1:0];
  assign clear_c = ui_in[2];
  assign pause_c = ui_in[3];
  assign div_c   = ui_in[7:4];

  assign unused_bits = uio_in[3:0];

  assign tick_c = ena & ~pause_c & (pcnt == div_c);
  assign duty_c = {uio_in[7:4], 4'h0};
  assign pwm_c  = (cnt < duty_c);
  assign fb_c   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Output pattern selection.
  always_comb begin
    mux_c = cnt;
    unique case (mode_c)
      2'b00: mux_c = cnt;
      2'b01: mux_c = lfsr[7:0];
      2'b10: mux_c = {CNT_W{pwm_c}};
      2'b11: mux_c = lfsr[15:8];
      default: mux_c = cnt;
    endcase
  end

  // Prescaler, counter and LFSR; clear wins over pause and tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      cnt  <= '0;
      lfsr <= LFSR_SEED;
    end else if (ena) begin
      if (clear_c) begin
        pcnt <= '0;
        cnt  <= '0;
        lfsr <= LFSR_SEED;
      end else if (!pause_c) begin
        if (tick_c) begin
          pcnt <= '0;
          cnt  <= cnt + CNT_W'(1);
          lfsr <= {lfsr[14:0], fb_c};
        end else begin
          pcnt <= pcnt + PCNT_W'(1);
        end
      end
    end
  end

  // Registered outputs reflect pre-update state (one-cycle lag).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_out <= '0;
      status <= '0;
    end else if (ena) begin
      uo_out <= mux_c;
      status <= {pwm_c, lfsr[15], tick_c, (cnt == 8'hFF)};
    end
  end

  assign uio_out = {4'h0, status};
  assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_pchri03_top.sv
// Scoreboard bench for pchri03_top: stimulus queues hand-computed expectations tagged
// with the clock edge they apply to; a negedge monitor pops and compares them.
module tb_pchri03_top;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  pchri03_top dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         tag;
    logic [7:0] uo;
    logic [3:0] st;
    logic [3:0] m;
  } exp_t;

  exp_t q[$];
  int   n_edges = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  always @(posedge clk) n_edges <= n_edges + 1;

  // Monitor: compare every expectation due at or before the current edge count.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tag <= n_edges) begin
      exp_t e;
      logic [7:0] msk;
      e   = q.pop_front();
      msk = {4'hF, e.m};
      n_cmp++;
      if (e.tag != n_edges ||
          uo_out !== e.uo ||
          (uio_out & msk) !== ({4'h0, e.st} & msk) ||
          uio_oe !== 8'h0F) begin
        n_bad++;
        $display("FAIL %s edge=%0d(due %0d): uo_out=%h uio_out=%h uio_oe=%h, required uo_out=%h uio_out&%h=%h uio_oe=0f",
                 e.name, n_edges, e.tag, uo_out, uio_out, uio_oe, e.uo, msk, {4'h0, e.st} & msk);
      end
    end
  end

  task automatic push(input string name, input int tag, input logic [7:0] uo,
                      input logic [3:0] st, input logic [3:0] m);
    exp_t e;
    e.name = name; e.tag = tag; e.uo = uo; e.st = st; e.m = m;
    q.push_back(e);
  endtask

  // Drive inputs for the next edge, queue its expectation, advance one clock.
  task automatic cyc(input string name, input logic [7:0] ui, input logic [7:0] uio,
                     input logic e, input logic [7:0] uo, input logic [3:0] st,
                     input logic [3:0] m);
    ui_in  = ui;
    uio_in = uio;
    ena    = e;
    push(name, n_edges + 1, uo, st, m);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    @(posedge clk);
    #1;
    push("reset", n_edges, 8'h00, 4'h0, 4'hF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Free-running count, DIV=0, one-cycle lag.
    cyc("cnt0", 8'h00, 8'h00, 1'b1, 8'h00, 4'h6, 4'hF);
    for (int k = 1; k < 4; k++)
      cyc("cnt_run", 8'h00, 8'h00, 1'b1, 8'(k), 4'h2, 4'hB);

    // Clear, then LFSR low/high bytes.
    cyc("clear_a", 8'h04, 8'h00, 1'b1, 8'h04, 4'h0, 4'h0);
    cyc("lfsr_e1", 8'h01, 8'h00, 1'b1, 8'hE1, 4'h6, 4'hF);
    cyc("lfsr_c3", 8'h01, 8'h00, 1'b1, 8'hC3, 4'h2, 4'hF);
    cyc("lfsr_hi", 8'h03, 8'h00, 1'b1, 8'hB3, 4'h6, 4'hF);

    // DIV=3: tick every 4th edge.
    cyc("clear_b", 8'h34, 8'h00, 1'b1, 8'h03, 4'h0, 4'h0);
    for (int k = 0; k < 8; k++)
      cyc("div3", 8'h30, 8'h00, 1'b1, 8'(k / 4), (k % 4 == 3) ? 4'h2 : 4'h0, 4'h2);

    // Pause freezes state, outputs keep refreshing.
    for (int k = 0; k < 3; k++)
      cyc("pause", 8'h38, 8'h00, 1'b1, 8'h02, 4'h0, 4'h2);
    for (int k = 0; k < 4; k++)
      cyc("resume", 8'h30, 8'h00, 1'b1, 8'h02, (k == 3) ? 4'h2 : 4'h0, 4'h2);

    // ena=0 freeze (clear requested but ignored), then resume.
    cyc("pre_hold3", 8'h00, 8'h00, 1'b1, 8'h03, 4'h2, 4'hB);
    cyc("pre_hold4", 8'h00, 8'h00, 1'b1, 8'h04, 4'h2, 4'hB);
    for (int k = 0; k < 10; k++)
      cyc("ena_hold", 8'h04, 8'h00, 1'b0, 8'h04, 4'h2, 4'hB);
    cyc("ena_res5", 8'h00, 8'h00, 1'b1, 8'h05, 4'h2, 4'hB);
    cyc("ena_res6", 8'h00, 8'h00, 1'b1, 8'h06, 4'h2, 4'hB);

    // PWM with duty 0x80 across a full count wrap.
    cyc("clear_c", 8'h04, 8'h00, 1'b1, 8'h07, 4'h0, 4'h0);
    for (int k = 1; k <= 256; k++)
      cyc("pwm80", 8'h02, 8'h80, 1'b1, (k <= 128) ? 8'hFF : 8'h00,
          (k <= 128) ? 4'h8 : ((k == 256) ? 4'h1 : 4'h0), 4'h9);
    cyc("wrap", 8'h02, 8'h80, 1'b1, 8'hFF, 4'h8, 4'h9);
    cyc("duty0_a", 8'h02, 8'h00, 1'b1, 8'h00, 4'h0, 4'h9);
    cyc("duty0_b", 8'h02, 8'h00, 1'b1, 8'h00, 4'h0, 4'h9);

    // Mid-operation asynchronous reset, then restart from seed.
    rst_n = 1'b0;
    push("reset_mid", n_edges, 8'h00, 4'h0, 4'hF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("post_rst_e1", 8'h01, 8'h00, 1'b1, 8'hE1, 4'h6, 4'hF);
    cyc("post_rst_c3", 8'h01, 8'h00, 1'b1, 8'hC3, 4'h2, 4'hF);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
